// File: rtl/c1541_pkg.sv
// Shared types, constants and track-geometry helpers for the 1541 track loader.
// Tracks are 1-based; each helper expects a track already clamped to 1..MAX_TRACK.
package c1541_pkg;

    localparam int MAX_TRACK = 40;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        WB_REQ,
        WB_WAIT,
        RD_REQ,
        RD_WAIT
    } state_t;

    function automatic logic [5:0] clamp_track(input logic [5:0] t);
        if (t == 6'd0) return 6'd1;
        if (t > 6'(MAX_TRACK)) return 6'(MAX_TRACK);
        return t;
    endfunction

    // The four speed zones of a 1541 disk.
    function automatic logic [4:0] track_sectors(input logic [5:0] t);
        if (t <= 6'd17) return 5'd21;
        if (t <= 6'd24) return 5'd19;
        if (t <= 6'd30) return 5'd18;
        return 5'd17;
    endfunction

    // Block offset of a track: zone base plus a whole number of tracks within the zone.
    function automatic logic [9:0] track_offset(input logic [5:0] t);
        logic [9:0] tw;
        tw = {4'd0, t};
        if (t <= 6'd17) return (tw - 10'd1)  * 10'd21;
        if (t <= 6'd24) return 10'd357 + (tw - 10'd18) * 10'd19;
        if (t <= 6'd30) return 10'd490 + (tw - 10'd25) * 10'd18;
        return 10'd598 + (tw - 10'd31) * 10'd17;
    endfunction

endpackage

// File: rtl/c1541_track_map.sv
// Combinational lookup of sector count and starting block for one track.
// The input is clamped here as well, so out-of-range values never index past the table.
module c1541_track_map
    import c1541_pkg::*;
(
    input  logic [5:0] track,
    output logic [4:0] sectors,
    output logic [9:0] offset
);

    logic [5:0] track_c;

    assign track_c = clamp_track(track);
    assign sectors = track_sectors(track_c);
    assign offset  = track_offset(track_c);

endmodule

// File: rtl/c1541_track_loader.sv
// Loads the D64 track under the head into the GCR stage buffer, with optional writeback.
// Define C1541_TRACK_WRITEBACK_EN to enable dirty tracking and the WB_REQ/WB_WAIT writeback path.
module c1541_track_loader
    import c1541_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  track,
    input  logic        img_mounted,
    input  logic        img_readonly,
    input  logic        we,
    output logic        busy,
    output logic [31:0] sd_lba,
    output logic [5:0]  sd_blk_cnt,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state, next_state;
    logic [CNT_W-1:0] settle_cnt;
    logic [5:0]       track_c, settle_track, target_track, loaded_track, map_track;
    logic             loaded_valid, mount_pending;
    logic             loaded_hit, settle_done, wb_needed, rd_in_flight;
    logic [4:0]       map_sectors;
    logic [9:0]       map_offset;

    assign track_c     = clamp_track(track);
    assign loaded_hit  = loaded_valid && (loaded_track == track_c);
    assign busy        = !((state == IDLE) && loaded_hit);
    assign settle_done = (state == SETTLE) && (settle_track == track_c) && (settle_cnt == CNT_LAST);
    assign sd_rd       = (state == RD_REQ);

    // A read still holding the handshake; a mount seen here must not validate the data it returns.
    assign rd_in_flight = (state == RD_REQ) || ((state == RD_WAIT) && sd_ack);

`ifdef C1541_TRACK_WRITEBACK_EN
    logic dirty;

    assign wb_needed = dirty && !img_mounted && !img_readonly;
    assign sd_wr     = (state == WB_REQ);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dirty <= 1'b0;
        end else if (img_mounted || img_readonly) begin
            dirty <= 1'b0;
        end else if ((state == WB_WAIT) && !sd_ack) begin
            dirty <= 1'b0;
        end else if (we && !busy) begin
            dirty <= 1'b1;
        end
    end
`else
    logic unused_wb_inputs;

    assign wb_needed        = 1'b0;
    assign sd_wr            = 1'b0;
    assign unused_wb_inputs = we ^ img_readonly;
`endif

    // Writeback addresses the old track; every other lookup targets the new one.
    assign map_track = (state == WB_WAIT) ? target_track :
                       (wb_needed ? loaded_track : track_c);

    c1541_track_map u_map (
        .track   (map_track),
        .sectors (map_sectors),
        .offset  (map_offset)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: next_state gets its default first, so no path through the case can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!loaded_hit) next_state = SETTLE;
            SETTLE:  if (settle_done) next_state = wb_needed ? WB_REQ : RD_REQ;
            WB_REQ:  if (sd_ack)      next_state = WB_WAIT;
            WB_WAIT: if (!sd_ack)     next_state = RD_REQ;
            RD_REQ:  if (sd_ack)      next_state = RD_WAIT;
            RD_WAIT: if (!sd_ack)     next_state = IDLE;
            default:                  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt    <= '0;
            settle_track  <= 6'd0;
            target_track  <= 6'd0;
            loaded_track  <= 6'd0;
            loaded_valid  <= 1'b0;
            mount_pending <= 1'b0;
            sd_lba        <= 32'd0;
            sd_blk_cnt    <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!loaded_hit) begin
                        settle_track <= track_c;
                        settle_cnt   <= '0;
                    end
                end
                SETTLE: begin
                    if (track_c != settle_track) begin
                        settle_track <= track_c;
                        settle_cnt   <= '0;
                    end else if (settle_cnt != CNT_LAST) begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                    if (settle_done) begin
                        target_track <= track_c;
                        sd_lba       <= {22'd0, map_offset};
                        sd_blk_cnt   <= {1'b0, map_sectors} - 6'd1;
                    end
                end
                WB_WAIT: begin
                    // Strobes are both low on this edge, so the address can switch to the read target.
                    if (!sd_ack) begin
                        sd_lba     <= {22'd0, map_offset};
                        sd_blk_cnt <= {1'b0, map_sectors} - 6'd1;
                    end
                end
                RD_WAIT: begin
                    if (!sd_ack) begin
                        loaded_track  <= target_track;
                        loaded_valid  <= !mount_pending;
                        mount_pending <= 1'b0;
                    end
                end
                default: ;
            endcase

            if (img_mounted) begin
                loaded_valid <= 1'b0;
                if (rd_in_flight) mount_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_c1541_track_loader.sv
// Directed self-checking bench for c1541_track_loader with a hand-driven SD host.
// Writeback expectations follow C1541_TRACK_WRITEBACK_EN, matching the RTL build.
module tb_c1541_track_loader;

    localparam int SETTLE = 16;
    localparam int LAT    = SETTLE + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  track;
    logic        img_mounted, img_readonly, we, sd_ack;
    logic        busy, sd_rd, sd_wr;
    logic [31:0] sd_lba;
    logic [5:0]  sd_blk_cnt;

    int n_cmp   = 0;
    int n_bad   = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    c1541_track_loader #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk          (clk),
        .reset        (reset),
        .track        (track),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .we           (we),
        .busy         (busy),
        .sd_lba       (sd_lba),
        .sd_blk_cnt   (sd_blk_cnt),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack)
    );

    always @(negedge clk) if (sd_rd && sd_wr) overlap++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(output int cycles, input int budget);
        cycles = 0;
        while (!(sd_rd || sd_wr) && cycles < budget) begin
            tick(1);
            cycles++;
        end
    endtask

    task automatic expect_req(input string tag, input bit wr, input logic [31:0] lba, input logic [5:0] cnt);
        int c;
        wait_strobe(c, 200);
        check({tag, ".sd_rd"},  {31'd0, sd_rd}, {31'd0, !wr});
        check({tag, ".sd_wr"},  {31'd0, sd_wr}, {31'd0, wr});
        check({tag, ".lba"},    sd_lba, lba);
        check({tag, ".blkcnt"}, {26'd0, sd_blk_cnt}, {26'd0, cnt});
    endtask

    task automatic finish_xfer(input string tag);
        sd_ack = 1'b1;
        tick(1);
        check({tag, ".strobe_drop"}, {30'd0, sd_rd, sd_wr}, 32'd0);
        sd_ack = 1'b0;
        tick(1);
    endtask

    initial begin
        int c;
        int seen;

        // Reset state
        reset = 1'b1; track = 6'd1; img_mounted = 1'b0; img_readonly = 1'b0; we = 1'b0; sd_ack = 1'b0;
        tick(2);
        check("rst.busy",   {31'd0, busy},  32'd1);
        check("rst.strobe", {30'd0, sd_rd, sd_wr}, 32'd0);
        check("rst.lba",    sd_lba, 32'd0);
        check("rst.blkcnt", {26'd0, sd_blk_cnt}, 32'd0);
        reset = 1'b0;
        check("post_rst.busy", {31'd0, busy}, 32'd1);

        // First load of track 1
        wait_strobe(c, 200);
        check("t1.latency", c, LAT);
        expect_req("t1", 1'b0, 32'd0, 6'd20);
        finish_xfer("t1");
        check("t1.busy", {31'd0, busy}, 32'd0);

        // Dirty track 1, then move to 18
        we = 1'b1; tick(1); we = 1'b0;
        track = 6'd18;
`ifdef C1541_TRACK_WRITEBACK_EN
        expect_req("wb_t1", 1'b1, 32'd0, 6'd20);
        finish_xfer("wb_t1");
`endif
        expect_req("t18", 1'b0, 32'd357, 6'd18);
        finish_xfer("t18");
        check("t18.busy", {31'd0, busy}, 32'd0);

        // Toggling head never settles; a we while busy is dropped
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            track = (k % 2 == 0) ? 6'd19 : 6'd18;
            if (k == 2) we = 1'b1;
            for (int j = 0; j < SETTLE / 2; j++) begin
                tick(1);
                we = 1'b0;
                if (sd_rd || sd_wr) seen++;
            end
        end
        check("toggle.strobes", seen, 0);
        check("toggle.busy", {31'd0, busy}, 32'd1);
        track = 6'd19;
        wait_strobe(c, 200);
        check("t19.latency", c, LAT);
        expect_req("t19", 1'b0, 32'd376, 6'd18);
        finish_xfer("t19");
        check("t19.busy", {31'd0, busy}, 32'd0);

        // Track change during RD_WAIT is deferred
        track = 6'd18;
        expect_req("mid.t18", 1'b0, 32'd357, 6'd18);
        sd_ack = 1'b1; tick(1);
        track = 6'd19; tick(2);
        check("mid.sd_rd", {31'd0, sd_rd}, 32'd0);
        check("mid.lba_held", sd_lba, 32'd357);
        sd_ack = 1'b0; tick(1);
        check("mid.busy", {31'd0, busy}, 32'd1);
        wait_strobe(c, 200);
        check("mid.latency", c, LAT);
        expect_req("mid.t19", 1'b0, 32'd376, 6'd18);
        finish_xfer("mid.t19");

        // Write-protected image never writes back
        img_readonly = 1'b1;
        we = 1'b1; tick(1); we = 1'b0; tick(1);
        we = 1'b1; tick(1); we = 1'b0;
        track = 6'd36;
        expect_req("ro.t36", 1'b0, 32'd683, 6'd16);
        finish_xfer("ro.t36");
        check("ro.busy", {31'd0, busy}, 32'd0);
        img_readonly = 1'b0;

        // Reset mid-handshake
        track = 6'd1;
        expect_req("rr.t1", 1'b0, 32'd0, 6'd20);
        reset = 1'b1; #1;
        check("rr.sd_rd", {31'd0, sd_rd}, 32'd0);
        check("rr.lba",   sd_lba, 32'd0);
        tick(2);
        reset = 1'b0;
        wait_strobe(c, 200);
        check("rr.latency", c, LAT);
        expect_req("rr.fresh", 1'b0, 32'd0, 6'd20);
        finish_xfer("rr.fresh");
        check("rr.busy", {31'd0, busy}, 32'd0);

        // Image insertion while idle and while a read is in flight
        img_mounted = 1'b1; tick(1); img_mounted = 1'b0;
        check("mnt.busy", {31'd0, busy}, 32'd1);
        wait_strobe(c, 200);
        check("mnt.latency", c, LAT);
        expect_req("mnt.t1", 1'b0, 32'd0, 6'd20);
        sd_ack = 1'b1; tick(1);
        img_mounted = 1'b1; tick(1); img_mounted = 1'b0;
        sd_ack = 1'b0; tick(1);
        check("mnt_rd.busy", {31'd0, busy}, 32'd1);
        expect_req("mnt.reload", 1'b0, 32'd0, 6'd20);
        finish_xfer("mnt.reload");
        check("mnt.reload_busy", {31'd0, busy}, 32'd0);

        // Clamping and an extra zone boundary
        track = 6'd45;
        expect_req("clamp_hi", 1'b0, 32'd751, 6'd16);
        finish_xfer("clamp_hi");
        track = 6'd40; tick(3);
        check("t40.busy",  {31'd0, busy},  32'd0);
        check("t40.sd_rd", {31'd0, sd_rd}, 32'd0);
        track = 6'd0;
        expect_req("clamp_lo", 1'b0, 32'd0, 6'd20);
        finish_xfer("clamp_lo");
        track = 6'd25;
        expect_req("t25", 1'b0, 32'd490, 6'd17);
        finish_xfer("t25");
        check("t25.busy", {31'd0, busy}, 32'd0);

        check("strobe_overlap", overlap, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
